dmem_responder: RTL and testbench

//  Memory-side responder for the CPU data-memory load/store interface. It

---
 rtl/dmem_responder.sv | 115 +++++++++++
 tb/tb_dmem_responder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store per handshake, fixed access latency,
// single-cycle response strobe with read data and an error flag.
module dmem_responder #(
    parameter int DEPTH_WORDS = 128,
    parameter int LATENCY     = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        req_ready_o,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               write_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic               ready_q;
    logic               valid_q;
    logic [31:0]        rdata_q;
    logic               err_q;
    logic [31:0]        mem_q [DEPTH_WORDS];

    logic [IDX_W-1:0]   idx;
    logic               addr_err;
    logic               commit;

    // Decoded from the latched request so late input changes cannot leak in.
    assign idx      = addr_q[IDX_W+1:2];
    assign addr_err = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= 30'(DEPTH_WORDS));
    assign commit   = (state_q == WAIT) && (cnt_q == '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (commit && write_q && !addr_err) begin
            mem_q[idx] <= wdata_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        write_q <= req_write_i;
                        addr_q  <= req_addr_i;
                        wdata_q <= req_wdata_i;
                        cnt_q   <= CNT_W'(LATENCY - 1);
                        ready_q <= 1'b0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        valid_q <= 1'b1;
                        state_q <= RESP;
                        if (addr_err) begin
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                        end else begin
                            err_q   <= 1'b0;
                            rdata_q <= write_q ? 32'h0 : mem_q[idx];
                        end
                    end
                end
                RESP: begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready_o  = ready_q;
    assign resp_valid_o = valid_q;
    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: default build (LATENCY=2, 128 words)
// plus a LATENCY=1, 512-word build sharing clock and reset.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_write, req_ready, resp_valid, resp_err;
    logic [31:0] req_addr, req_wdata, resp_rdata;
    logic        b_valid, b_write, b_ready, b_resp_valid, b_resp_err;
    logic [31:0] b_addr, b_wdata, b_resp_rdata;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(128), .LATENCY(2)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_write_i(req_write),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .req_ready_o(req_ready), .resp_valid_o(resp_valid),
        .resp_rdata_o(resp_rdata), .resp_err_o(resp_err)
    );

    dmem_responder #(.DEPTH_WORDS(512), .LATENCY(1)) u_dut_l1 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(b_valid), .req_write_i(b_write),
        .req_addr_i(b_addr), .req_wdata_i(b_wdata),
        .req_ready_o(b_ready), .resp_valid_o(b_resp_valid),
        .resp_rdata_o(b_resp_rdata), .resp_err_o(b_resp_err)
    );

    // Handshake: a request is accepted on a rising edge where req_valid & req_ready
    // are both high; the response is the single cycle where resp_valid is high.
    task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          output int lat, output logic [31:0] rdata, output logic err,
                          output logic stuck);
        int k;
        k = 0;
        @(negedge clk);
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_write = 1'($urandom_range(0, 1));
        lat = 0;
        while (!resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rdata = resp_rdata;
        err   = resp_err;
        @(negedge clk);
        stuck = resp_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        b_valid = 1'b0; b_write = 1'b0; b_addr = '0; b_wdata = '0;
        repeat (2) @(negedge clk);
        compared++; if (req_ready !== 1'b1) begin mismatched++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
        compared++; if (resp_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b expected 0", resp_valid); end
        compared++; if (resp_rdata !== 32'h0) begin mismatched++; $display("FAIL reset_rdata: got %h expected 0", resp_rdata); end
        compared++; if (resp_err !== 1'b0) begin mismatched++; $display("FAIL reset_err: got %b expected 0", resp_err); end
        compared++; if (b_ready !== 1'b1) begin mismatched++; $display("FAIL reset_ready_l1: got %b expected 1", b_ready); end
        rst = 1'b0;
    endtask

    task automatic test_store_load();
        int lat; logic [31:0] rd; logic er, st;
        do_req(1'b1, 32'h10, 32'hDEADBEEF, lat, rd, er, st);
        compared++; if (lat !== 2) begin mismatched++; $display("FAIL store_latency: got %0d expected 2", lat); end
        compared++; if (er !== 1'b0) begin mismatched++; $display("FAIL store_err: got %b expected 0", er); end
        compared++; if (rd !== 32'h0) begin mismatched++; $display("FAIL store_rdata: got %h expected 0", rd); end
        compared++; if (st !== 1'b0) begin mismatched++; $display("FAIL store_pulse_width: resp_valid got %b expected 0", st); end
        do_req(1'b0, 32'h10, 32'h0, lat, rd, er, st);
        compared++; if (lat !== 2) begin mismatched++; $display("FAIL load_latency: got %0d expected 2", lat); end
        compared++; if (rd !== 32'hDEADBEEF) begin mismatched++; $display("FAIL load_rdata: got %h expected deadbeef", rd); end
        compared++; if (er !== 1'b0) begin mismatched++; $display("FAIL load_err: got %b expected 0", er); end
        compared++; if (resp_rdata !== 32'hDEADBEEF) begin mismatched++; $display("FAIL rdata_hold: got %h expected deadbeef", resp_rdata); end
    endtask

    task automatic test_misaligned();
        int lat; logic [31:0] rd; logic er, st;
        do_req(1'b1, 32'h13, 32'h12345678, lat, rd, er, st);
        compared++; if (er !== 1'b1) begin mismatched++; $display("FAIL misaligned_err: got %b expected 1", er); end
        compared++; if (rd !== 32'h0) begin mismatched++; $display("FAIL misaligned_rdata: got %h expected 0", rd); end
        compared++; if (resp_err !== 1'b1) begin mismatched++; $display("FAIL err_hold: got %b expected 1", resp_err); end
        do_req(1'b0, 32'h10, 32'h0, lat, rd, er, st);
        compared++; if (rd !== 32'hDEADBEEF) begin mismatched++; $display("FAIL misaligned_no_write: got %h expected deadbeef", rd); end
        compared++; if (er !== 1'b0) begin mismatched++; $display("FAIL misaligned_next_err: got %b expected 0", er); end
    endtask

    task automatic test_out_of_range();
        int lat; logic [31:0] rd; logic er, st;
        do_req(1'b0, 32'h200, 32'h0, lat, rd, er, st);
        compared++; if (er !== 1'b1) begin mismatched++; $display("FAIL oor_err: got %b expected 1", er); end
        compared++; if (rd !== 32'h0) begin mismatched++; $display("FAIL oor_rdata: got %h expected 0", rd); end
        do_req(1'b1, 32'h400, 32'h11111111, lat, rd, er, st);
        compared++; if (er !== 1'b1) begin mismatched++; $display("FAIL oor_store_err: got %b expected 1", er); end
        do_req(1'b1, 32'h1FC, 32'h0BADF00D, lat, rd, er, st);
        compared++; if (er !== 1'b0) begin mismatched++; $display("FAIL last_word_err: got %b expected 0", er); end
        do_req(1'b0, 32'h1FC, 32'h0, lat, rd, er, st);
        compared++; if (rd !== 32'h0BADF00D) begin mismatched++; $display("FAIL last_word_rdata: got %h expected 0badf00d", rd); end
        do_req(1'b0, 32'h0, 32'h0, lat, rd, er, st);
        compared++; if (rd !== 32'h0) begin mismatched++; $display("FAIL oor_no_alias: got %h expected 0", rd); end
    endtask

    task automatic test_reset_in_wait();
        int lat, seen; logic [31:0] rd; logic er, st;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        compared++; if (resp_valid !== 1'b0) begin mismatched++; $display("FAIL wait_reset_valid: got %b expected 0", resp_valid); end
        compared++; if (req_ready !== 1'b1) begin mismatched++; $display("FAIL wait_reset_ready: got %b expected 1", req_ready); end
        #2 rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        compared++; if (seen !== 0) begin mismatched++; $display("FAIL wait_reset_no_resp: got %0d pulses expected 0", seen); end
        do_req(1'b0, 32'h20, 32'h0, lat, rd, er, st);
        compared++; if (rd !== 32'h0) begin mismatched++; $display("FAIL wait_reset_no_write: got %h expected 0", rd); end
        do_req(1'b0, 32'h10, 32'h0, lat, rd, er, st);
        compared++; if (rd !== 32'h0) begin mismatched++; $display("FAIL reset_clears_array: got %h expected 0", rd); end
    endtask

    task automatic test_reset_in_resp();
        int k;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h4; req_wdata = 32'h0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        while (!resp_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        compared++; if (resp_valid !== 1'b1) begin mismatched++; $display("FAIL resp_reached: got %b expected 1", resp_valid); end
        #1 rst = 1'b1;
        #1;
        compared++; if (resp_valid !== 1'b0) begin mismatched++; $display("FAIL resp_reset_async: got %b expected 0", resp_valid); end
        #1 rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [13:0] mask, exp_mask;
        int pulses;
        mask = '0;
        exp_mask = 14'b00000100010001;
        pulses = 0;
        @(negedge clk);
        req_write = 1'b0; req_addr = 32'h8; req_wdata = 32'h0;
        for (int k = 0; k < 14; k++) begin
            req_valid = (k < 10);
            if (resp_valid) pulses++;
            if (req_ready && req_valid) mask[k] = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        req_valid = 1'b0;
        compared++; if (mask !== exp_mask) begin mismatched++; $display("FAIL b2b_accept_edges: got %b expected %b", mask, exp_mask); end
        compared++; if (pulses !== 3) begin mismatched++; $display("FAIL b2b_resp_pulses: got %0d expected 3", pulses); end
    endtask

    task automatic test_latency_one();
        @(negedge clk);
        b_valid = 1'b1; b_write = 1'b1; b_addr = 32'h7FC; b_wdata = 32'h600DCAFE;
        @(posedge clk);
        @(negedge clk);
        b_valid = 1'b0;
        compared++; if (b_resp_valid !== 1'b0) begin mismatched++; $display("FAIL l1_early_valid: got %b expected 0", b_resp_valid); end
        @(negedge clk);
        compared++; if (b_resp_valid !== 1'b1) begin mismatched++; $display("FAIL l1_store_valid: got %b expected 1", b_resp_valid); end
        compared++; if (b_resp_err !== 1'b0) begin mismatched++; $display("FAIL l1_store_err: got %b expected 0", b_resp_err); end
        @(negedge clk);
        b_valid = 1'b1; b_write = 1'b0; b_addr = 32'h7FC; b_wdata = 32'h0;
        @(posedge clk);
        @(negedge clk);
        b_valid = 1'b0;
        @(negedge clk);
        compared++; if (b_resp_valid !== 1'b1) begin mismatched++; $display("FAIL l1_load_valid: got %b expected 1", b_resp_valid); end
        compared++; if (b_resp_rdata !== 32'h600DCAFE) begin mismatched++; $display("FAIL l1_load_rdata: got %h expected 600dcafe", b_resp_rdata); end
        compared++; if (b_resp_err !== 1'b0) begin mismatched++; $display("FAIL l1_load_err: got %b expected 0", b_resp_err); end
        @(negedge clk);
        b_valid = 1'b1; b_write = 1'b0; b_addr = 32'h800;
        @(posedge clk);
        @(negedge clk);
        b_valid = 1'b0;
        @(negedge clk);
        compared++; if (b_resp_err !== 1'b1) begin mismatched++; $display("FAIL l1_oor_err: got %b expected 1", b_resp_err); end
        compared++; if (b_resp_rdata !== 32'h0) begin mismatched++; $display("FAIL l1_oor_rdata: got %h expected 0", b_resp_rdata); end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_misaligned();
        test_out_of_range();
        test_reset_in_wait();
        test_reset_in_resp();
        test_back_to_back();
        test_latency_one();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
